// File: rtl/glyph_rain_engine_pkg.sv
// Shared types and constants for the glyph rain engine: mode encoding,
// per-column state record, sweep FSM states and LFSR parameters.
package glyph_rain_pkg;

   localparam int NUM_GLYPHS = 51;

   typedef enum logic [1:0] {
      MODE_RAIN    = 2'b00,
      MODE_FREEZE  = 2'b01,
      MODE_STATIC  = 2'b10,
      MODE_REVERSE = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_e;

   typedef struct packed {
      logic [6:0] head;
      logic [1:0] speed;
      logic [1:0] phase;
      logic [5:0] seed;
   } col_state_t;

   // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [5:0] seedFromLfsr(input logic [7:0] lfsrLow);
      return 6'(lfsrLow[7:2] % 6'(NUM_GLYPHS));
   endfunction

endpackage

// File: rtl/glyph_rain_engine_if.sv
// Beam-position inputs, mode control and per-pixel glyph outputs of the rain engine.
interface glyph_rain_engine_if #(
   parameter int CELL_W = 8
);
   localparam int XW = (CELL_W > 1) ? $clog2(CELL_W) : 1;

   logic [9:0]    hpos;
   logic [9:0]    vpos;
   logic          display_on;
   logic          frame_start;
   logic [1:0]    mode;
   logic [5:0]    glyph_idx;
   logic [XW-1:0] cell_x;
   logic [3:0]    cell_y;
   logic [3:0]    trail;
   logic          lit;
   logic          busy;

   modport master (
      output hpos, vpos, display_on, frame_start, mode,
      input  glyph_idx, cell_x, cell_y, trail, lit, busy
   );

   modport slave (
      input  hpos, vpos, display_on, frame_start, mode,
      output glyph_idx, cell_x, cell_y, trail, lit, busy
   );

endinterface

// File: rtl/glyph_rain_engine_lfsr.sv
// 16-bit LFSR that only advances when enabled; exposes the low byte used for respawns.
module rain_lfsr16
   import glyph_rain_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   output logic [7:0] o_low
);

   logic [15:0] r_state;
   logic        w_feedback;

   assign w_feedback = ^(r_state & LFSR_TAPS);
   assign o_low      = r_state[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= LFSR_SEED;
      else if (i_en)
         r_state <= {w_feedback, r_state[15:1]};
   end

endmodule

// File: rtl/glyph_rain_engine.sv
// Matrix-style glyph rain: a once-per-frame column sweep updates per-column heads,
// and a 2-stage pixel pipeline turns beam position into glyph index and trail info.
module glyph_rain_engine
   import glyph_rain_pkg::*;
#(
   parameter int NUM_COLS  = 80,
   parameter int NUM_ROWS  = 40,
   parameter int CELL_W    = 8,
   parameter int CELL_H    = 12,
   parameter int TRAIL_LEN = 12
) (
   input logic                clk,
   input logic                rst_n,
   glyph_rain_engine_if.slave bus
);

   localparam int         XW        = (CELL_W > 1) ? $clog2(CELL_W) : 1;
   localparam int         WRAP      = NUM_ROWS + TRAIL_LEN;
   localparam logic [6:0] WRAP_HEAD = 7'(WRAP - 1);
   localparam logic [6:0] LAST_COL  = 7'(NUM_COLS - 1);

   sweep_state_e r_state;
   logic [6:0]   r_sweepCol;
   logic         r_busy;
   col_state_t   r_cols [NUM_COLS];

   mode_e        w_mode;
   logic         w_lfsrEn;
   logic [7:0]   w_lfsr;
   col_state_t   w_cur;
   col_state_t   w_next;
   logic         w_respawn;

   assign w_mode   = mode_e'(bus.mode);
   assign w_lfsrEn = (r_state == ST_SWEEP) && (w_mode != MODE_FREEZE);

   rain_lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_lfsrEn),
      .o_low (w_lfsr)
   );

   // Column under the sweep pointer moves one cell each time its phase catches its speed
   always_comb begin
      w_cur     = r_cols[r_sweepCol];
      w_next    = w_cur;
      w_respawn = 1'b0;
      if (w_mode == MODE_RAIN || w_mode == MODE_REVERSE) begin
         if (w_cur.phase != w_cur.speed) begin
            w_next.phase = w_cur.phase + 2'd1;
         end else begin
            w_next.phase = 2'd0;
            if (w_mode == MODE_RAIN) begin
               w_respawn   = (w_cur.head == WRAP_HEAD);
               w_next.head = w_respawn ? 7'd0 : w_cur.head + 7'd1;
            end else begin
               w_respawn   = (w_cur.head == 7'd0);
               w_next.head = w_respawn ? WRAP_HEAD : w_cur.head - 7'd1;
            end
         end
         if (w_respawn) begin
            w_next.speed = w_lfsr[1:0];
            w_next.seed  = seedFromLfsr(w_lfsr);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_sweepCol <= 7'd0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.frame_start) begin
                  r_state    <= ST_SWEEP;
                  r_sweepCol <= 7'd0;
                  r_busy     <= 1'b1;
               end
            end
            ST_SWEEP: begin
               if (r_sweepCol == LAST_COL) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_sweepCol <= r_sweepCol + 7'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_COLS; c++) begin
            r_cols[c].head  <= 7'((5 * c) % WRAP);
            r_cols[c].speed <= 2'(c % 4);
            r_cols[c].phase <= 2'd0;
            r_cols[c].seed  <= 6'(c % NUM_GLYPHS);
         end
      end else if (r_state == ST_SWEEP) begin
         r_cols[r_sweepCol] <= w_next;
      end
   end

   logic [9:0]    w_colFull;
   logic [9:0]    w_rowFull;
   logic          w_colOk;
   logic          w_rowOk;
   col_state_t    w_rd;

   assign w_colFull = bus.hpos / 10'(CELL_W);
   assign w_rowFull = bus.vpos / 10'(CELL_H);
   assign w_colOk   = w_colFull < 10'(NUM_COLS);
   assign w_rowOk   = w_rowFull < 10'(NUM_ROWS);
   // Reading before the sweep's NBA lands gives pre-update state on a same-column hit
   assign w_rd      = w_colOk ? r_cols[w_colFull[6:0]] : '0;

   logic          r_s1Visible;
   logic          r_s1Static;
   logic [6:0]    r_s1Col;
   logic [6:0]    r_s1Row;
   logic [6:0]    r_s1Head;
   logic [5:0]    r_s1Seed;
   logic [XW-1:0] r_s1CellX;
   logic [3:0]    r_s1CellY;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Visible <= 1'b0;
         r_s1Static  <= 1'b0;
         r_s1Col     <= 7'd0;
         r_s1Row     <= 7'd0;
         r_s1Head    <= 7'd0;
         r_s1Seed    <= 6'd0;
         r_s1CellX   <= '0;
         r_s1CellY   <= 4'd0;
      end else begin
         r_s1Visible <= bus.display_on && w_colOk && w_rowOk;
         r_s1Static  <= (w_mode == MODE_STATIC);
         r_s1Col     <= w_colFull[6:0];
         r_s1Row     <= w_rowFull[6:0];
         r_s1Head    <= w_rd.head;
         r_s1Seed    <= w_rd.seed;
         r_s1CellX   <= bus.hpos[XW-1:0];
         r_s1CellY   <= 4'(bus.vpos % 10'(CELL_H));
      end
   end

   logic [8:0]    w_diff;
   logic          w_inTrail;
   logic          w_lit;
   logic [10:0]   w_glyphSum;

   assign w_diff     = {2'b00, r_s1Head} - {2'b00, r_s1Row};
   assign w_inTrail  = !w_diff[8] && (w_diff[7:0] < 8'(TRAIL_LEN));
   assign w_lit      = r_s1Visible && (r_s1Static || w_inTrail);
   assign w_glyphSum = 11'(r_s1Seed) + 11'(r_s1Row) * 11'd3 + 11'(r_s1Col) * 11'd7;

   logic [5:0]    r_glyph;
   logic [XW-1:0] r_cellX;
   logic [3:0]    r_cellY;
   logic [3:0]    r_trail;
   logic          r_lit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_glyph <= 6'd0;
         r_cellX <= '0;
         r_cellY <= 4'd0;
         r_trail <= 4'd0;
         r_lit   <= 1'b0;
      end else begin
         r_glyph <= 6'(w_glyphSum % 11'(NUM_GLYPHS));
         r_cellX <= r_s1CellX;
         r_cellY <= r_s1CellY;
         r_trail <= (w_lit && !r_s1Static) ? w_diff[3:0] : 4'd0;
         r_lit   <= w_lit;
      end
   end

   assign bus.glyph_idx = r_glyph;
   assign bus.cell_x    = r_cellX;
   assign bus.cell_y    = r_cellY;
   assign bus.trail     = r_trail;
   assign bus.lit       = r_lit;
   assign bus.busy      = r_busy;

endmodule

// File: doc/glyph_rain_engine.md
GLYPH_RAIN_ENGINE -- requirements
Module: glyph_rain_engine

Interface
REQ-001 SHALL have parameter NUM_COLS, default 80, number of glyph columns (1..128).
REQ-002 SHALL have parameter NUM_ROWS, default 40, number of glyph rows (1..64).
REQ-003 SHALL have parameter CELL_W, default 8, glyph cell width in pixels (power of two).
REQ-004 SHALL have parameter CELL_H, default 12, glyph cell height in pixels.
REQ-005 SHALL have parameter TRAIL_LEN, default 12, lit trail length in cells (1..15).
REQ-006 SHALL have port clk, input, 1, pixel clock.
REQ-007 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have ports hpos and vpos, input, 10 each, beam position from the sync generator.
REQ-009 SHALL have port display_on, input, 1, visible-area flag.
REQ-010 SHALL have port frame_start, input, 1, one-cycle pulse at the start of vertical blanking.
REQ-011 SHALL have port mode, input, 2: 00 rain, 01 freeze, 10 static, 11 reverse.
REQ-012 SHALL have port glyph_idx, output, 6, glyph ROM index (0..50).
REQ-013 SHALL have ports cell_x (log2 CELL_W bits) and cell_y (4 bits), outputs, pixel offset within the cell.
REQ-014 SHALL have port trail, output, 4, distance from the column head (0 = head).
REQ-015 SHALL have port lit, output, 1, pixel is inside an active trail.
REQ-016 SHALL have port busy, output, 1, column sweep in progress.

Function
REQ-017 SHALL hold per-column state: head (7 bits), speed (2 bits), phase (2 bits), seed (6 bits).
REQ-018 SHALL run a sweep FSM with states IDLE and SWEEP:
- frame_start in IDLE enters SWEEP at column 0.
- SWEEP updates one column per clock and returns to IDLE after column NUM_COLS-1.
- busy is high in SWEEP.
REQ-019 SHALL ignore frame_start while in SWEEP and SHALL NOT restart the sweep.
REQ-020 SHALL, in rain mode, advance a column per sweep as follows:
- phase increments; on phase == speed, phase clears and head increments.
- head wrap is at NUM_ROWS+TRAIL_LEN.
REQ-021 SHALL, on head wrap, respawn the column:
- head = 0.
- speed = lfsr[1:0].
- seed = lfsr[7:2] mod 51.
REQ-022 SHALL step the LFSR once per SWEEP clock.
REQ-023 SHALL, in reverse mode, decrement head and wrap 0 to NUM_ROWS+TRAIL_LEN-1; respawn is otherwise as in REQ-021.
REQ-024 SHALL, in freeze mode, leave all column state and the LFSR unchanged; the sweep and busy still run.
REQ-025 SHALL, in static mode, force lit=1 for every visible cell and trail=0; column state freezes.
REQ-026 SHALL compute pixel outputs through a 2-stage pipeline:
- Latency is exactly 2 clocks from hpos/vpos/display_on.
- col = hpos/CELL_W; row = vpos/CELL_H; cell_y = vpos mod CELL_H.
REQ-027 SHALL compute trail = head-row, and set lit = display_on & 0<=trail<TRAIL_LEN & col<NUM_COLS & row<NUM_ROWS.
REQ-028 SHALL force trail to 0 when lit is 0.
REQ-029 SHALL compute glyph_idx = (seed + 3*row + 7*col) mod 51.
REQ-030 SHALL, when a pixel read and a sweep write hit the same column in one clock, return the pre-update state.

Reset
REQ-031 SHALL, on rst_n low, immediately drive:
- FSM to IDLE; busy=0, lit=0, trail=0, glyph_idx=0.
- Pipeline registers cleared.
- LFSR = 16'hACE1.
- Each column: head = (5*col) mod (NUM_ROWS+TRAIL_LEN), speed = col mod 4, phase = 0, seed = col mod 51.
REQ-032 SHALL abandon a sweep interrupted by reset; no partial state is retained beyond the reset values.

Structure
REQ-033 SHALL define in package glyph_rain_pkg:
- NUM_GLYPHS=51.
- The mode encoding constants.
- The column-state record type.
- LFSR seed and taps (x^16+x^14+x^13+x^11+1).
REQ-034 SHALL place the LFSR in sub-module rain_lfsr16 with an enable input.

Verification
REQ-035 Reset, then hpos=0, vpos=0, display_on=1 -> after 2 clocks: col 0, head 0, lit=1, trail=0, glyph_idx=0.
REQ-036 Rain mode, column 1 speed 1: two frame_start pulses -> column 1 head advances from 5 to 6; busy is high exactly NUM_COLS clocks per pulse.
REQ-037 Column head at 51 (NUM_ROWS+TRAIL_LEN-1), phase == speed -> next sweep: head 0, speed/seed taken from the LFSR value at that clock.
REQ-038 frame_start pulsed again 10 clocks into a sweep -> busy stays high NUM_COLS clocks total; no second sweep follows.
REQ-039 Freeze mode across 3 frames -> column state and the LFSR are bit-identical to their start values; static mode -> lit=1 over all visible cells, 0 in blanking.
REQ-040 rst_n asserted mid-sweep at column 40 -> outputs clear the same cycle; after release, the state equals the REQ-031 values.
